// File: rtl/dmac_ctrl_arb_pkg.sv
// Shared types and helpers for the DMA control-port arbiter.
package dmac_ctrl_arb_pkg;

    // Command lock state: IDLE arbitrates freely, LOCKED restricts to the owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Index width that stays at least one bit wide for tiny counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = (n <= 2) ? 1 : $clog2(n);
        return r;
    endfunction

endpackage

// File: rtl/dmac_ctrl_arb_idfifo.sv
// Port-index FIFO: remembers which requester owns each outstanding response.
module dmac_ctrl_arb_idfifo
    import dmac_ctrl_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push is accepted even when full.
    assign w_push  = push_i && (!full_o || w_pop);
    assign head_o  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dmac_ctrl_arb.sv
// N-port round-robin arbiter onto the DMA control target port, with in-order
// response routing and command-atomic locking of multi-word DMA commands.
module dmac_ctrl_arb
    import dmac_ctrl_arb_pkg::*;
#(
    parameter int unsigned NB_PORTS     = 3,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned PE_ID_WIDTH  = 4,
    parameter int unsigned MAX_OUTSTND  = 4,
    parameter logic [7:0]  CMD_OFFSET   = 8'h00,
    parameter int unsigned CMD_WORDS    = 3,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NB_PORTS-1:0]                   s_req_i,
    input  logic [NB_PORTS*ADDR_WIDTH-1:0]        s_add_i,
    input  logic [NB_PORTS-1:0]                   s_wen_i,
    input  logic [NB_PORTS*DATA_WIDTH-1:0]        s_wdata_i,
    input  logic [NB_PORTS*(DATA_WIDTH/8)-1:0]    s_be_i,
    output logic [NB_PORTS-1:0]                   s_gnt_o,
    output logic [NB_PORTS-1:0]                   s_r_valid_o,
    output logic [DATA_WIDTH-1:0]                 s_r_rdata_o,
    output logic                                  s_r_opc_o,
    output logic                                  m_req_o,
    output logic [ADDR_WIDTH-1:0]                 m_add_o,
    output logic                                  m_wen_o,
    output logic [DATA_WIDTH-1:0]                 m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]               m_be_o,
    output logic [PE_ID_WIDTH-1:0]                m_id_o,
    input  logic                                  m_gnt_i,
    input  logic                                  m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                 m_r_rdata_i,
    input  logic                                  m_r_opc_i,
    output logic                                  lock_err_o,
    output logic                                  busy_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = clog2_min1(NB_PORTS);
    localparam int unsigned WL_W     = $clog2(CMD_WORDS + 1);
    localparam int unsigned IC_W     = $clog2(LOCK_TIMEOUT + 1);

    // (base + off) mod NB_PORTS without assuming a power-of-two port count.
    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NB_PORTS) s = s - NB_PORTS;
        return IDX_W'(s);
    endfunction

    lock_state_e       r_state;
    lock_state_e       w_state_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  w_owner_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  w_rr_ptr_nxt;
    logic [WL_W-1:0]   r_words_left;
    logic [WL_W-1:0]   w_words_left_nxt;
    logic [IC_W-1:0]   r_idle_cnt;
    logic [IC_W-1:0]   w_idle_cnt_nxt;

    logic [NB_PORTS-1:0] w_elig;
    logic [IDX_W-1:0]    w_cand;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_win_valid;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [IDX_W-1:0]    w_fifo_head;
    logic                w_fifo_room;
    logic                w_xfer;
    logic                w_pop;
    logic                w_open_cmd;
    logic                w_owner_req;
    logic                w_lock_err;

    // Eligibility: while locked only the owner may compete.
    always_comb begin
        w_elig = s_req_i;
        if (r_state == LOCKED) w_elig = s_req_i & (NB_PORTS'(1) << r_owner);
    end

    // Round-robin search starting at the pointer; outputs forced idle in reset.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int unsigned i = 0; i < NB_PORTS; i++) begin
            w_cand = f_wrap(r_rr_ptr, i);
            if (!w_win_valid && w_elig[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
        w_win_valid = w_win_valid & rst_ni;
    end

    // A response popping this cycle frees a slot for a same-cycle grant.
    assign w_fifo_room = !w_fifo_full || m_r_valid_i;
    assign m_req_o     = w_win_valid && w_fifo_room;
    assign w_xfer      = m_req_o && m_gnt_i;
    assign w_pop       = m_r_valid_i && !w_fifo_empty && rst_ni;
    assign w_owner_req = s_req_i[r_owner];

    // Forward the winner's request fields to the target.
    always_comb begin
        m_add_o   = '0;
        m_wen_o   = 1'b0;
        m_wdata_o = '0;
        m_be_o    = '0;
        m_id_o    = '0;
        if (w_win_valid) begin
            m_add_o   = s_add_i[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            m_wen_o   = s_wen_i[w_win_idx];
            m_wdata_o = s_wdata_i[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
            m_be_o    = s_be_i[w_win_idx*BE_WIDTH +: BE_WIDTH];
            m_id_o    = PE_ID_WIDTH'(w_win_idx);
        end
    end

    assign s_gnt_o     = w_xfer ? (NB_PORTS'(1) << w_win_idx) : '0;
    assign s_r_valid_o = w_pop ? (NB_PORTS'(1) << w_fifo_head) : '0;
    assign s_r_rdata_o = rst_ni ? m_r_rdata_i : '0;
    assign s_r_opc_o   = rst_ni & m_r_opc_i;

    assign w_open_cmd = w_xfer && !m_wen_o && (m_add_o[7:0] == CMD_OFFSET) && (CMD_WORDS > 1);

    dmac_ctrl_arb_idfifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTND)
    ) u_idfifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_xfer),
        .data_i  (w_win_idx),
        .pop_i   (w_pop),
        .head_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Lock FSM and round-robin pointer next-state.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_words_left_nxt = r_words_left;
        w_idle_cnt_nxt   = r_idle_cnt;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_rr_ptr_nxt = f_wrap(w_win_idx, 1);
                    if (w_open_cmd) begin
                        w_state_nxt      = LOCKED;
                        w_owner_nxt      = w_win_idx;
                        w_words_left_nxt = WL_W'(CMD_WORDS - 1);
                        w_idle_cnt_nxt   = '0;
                    end
                end
            end
            LOCKED: begin
                // Only the owner can be granted here; reads keep the count.
                if (w_xfer) begin
                    w_idle_cnt_nxt = '0;
                    if (!m_wen_o) begin
                        if (r_words_left != '0) w_words_left_nxt = r_words_left - WL_W'(1);
                        if (r_words_left <= WL_W'(1)) begin
                            w_state_nxt  = IDLE;
                            w_rr_ptr_nxt = f_wrap(r_owner, 1);
                        end
                    end
                end else if (!w_owner_req) begin
                    if (r_idle_cnt != '1) w_idle_cnt_nxt = r_idle_cnt + IC_W'(1);
                    if (r_idle_cnt >= IC_W'(LOCK_TIMEOUT - 1)) begin
                        w_state_nxt  = IDLE;
                        w_lock_err   = 1'b1;
                        w_rr_ptr_nxt = f_wrap(r_owner, 1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign lock_err_o = w_lock_err;
    assign busy_o     = !w_fifo_empty || (r_state == LOCKED);

    // Lock FSM and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_words_left <= '0;
            r_idle_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_words_left <= w_words_left_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
        end
    end

    // A response with nothing outstanding has no destination and is dropped.
    a_resp_needs_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(m_r_valid_i && w_fifo_empty));

endmodule

// File: tb/tb_dmac_ctrl_arb.sv
// Bench for dmac_ctrl_arb: directed scenarios plus randomized traffic against
// a queue-based model of grant order, lock rules and response routing.
module tb_dmac_ctrl_arb;

    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int IDW  = 4;
    localparam int MAXO = 4;
    localparam int CMDW = 3;
    localparam int TO   = 16;
    localparam logic [7:0] CMD_OFF = 8'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req, wen, gnt, rv;
    logic [N*AW-1:0] add;
    logic [N*DW-1:0] wdata;
    logic [N*BW-1:0] be;
    logic [DW-1:0]   rdata, m_wdata, m_rdata;
    logic            ropc, m_req, m_wen, m_gnt, m_rv, m_ropc, lock_err, busy;
    logic [AW-1:0]   m_add;
    logic [BW-1:0]   m_be;
    logic [IDW-1:0]  m_id;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  mrr, mowner, mwords, midle;
    bit  mlocked;
    int  q[$];
    int  exp_win;
    bit  exp_req, exp_err, exp_busy;
    logic [N-1:0] exp_gnt, exp_rv;

    dmac_ctrl_arb #(
        .NB_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PE_ID_WIDTH(IDW),
        .MAX_OUTSTND(MAXO), .CMD_OFFSET(CMD_OFF), .CMD_WORDS(CMDW), .LOCK_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_req_i(req), .s_add_i(add), .s_wen_i(wen), .s_wdata_i(wdata), .s_be_i(be),
        .s_gnt_o(gnt), .s_r_valid_o(rv), .s_r_rdata_o(rdata), .s_r_opc_o(ropc),
        .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen), .m_wdata_o(m_wdata),
        .m_be_o(m_be), .m_id_o(m_id), .m_gnt_i(m_gnt), .m_r_valid_i(m_rv),
        .m_r_rdata_i(m_rdata), .m_r_opc_i(m_ropc),
        .lock_err_o(lock_err), .busy_o(busy)
    );

    function automatic logic [31:0] naddr(input int p);
        return {24'($urandom), 8'(8'h10 + p)};
    endfunction

    function automatic logic [31:0] cmdaddr();
        return {24'($urandom), CMD_OFF};
    endfunction

    task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] a);
        req[p] = r;
        wen[p] = w;
        add[p*AW +: AW]   = a;
        wdata[p*DW +: DW] = $urandom;
        be[p*BW +: BW]    = 4'($urandom);
    endtask

    // Expected outputs for the current inputs, from the arbitration rules.
    task automatic predict();
        int p;
        exp_win = -1;
        for (int i = 0; i < N; i++) begin
            p = (mrr + i) % N;
            if (exp_win < 0 && req[p] && (!mlocked || p == mowner)) exp_win = p;
        end
        exp_req  = rst_n && (exp_win >= 0) && ((q.size() < MAXO) || m_rv);
        exp_gnt  = (exp_req && m_gnt) ? (N'(1) << exp_win) : '0;
        exp_rv   = (m_rv && q.size() > 0) ? (N'(1) << q[0]) : '0;
        exp_err  = mlocked && !req[mowner] && (midle + 1 >= TO);
        exp_busy = (q.size() > 0) || mlocked;
    endtask

    // Apply this cycle's events to the model, then move to just after the next edge.
    task automatic advance();
        bit granted;
        int w, dummy;
        granted = exp_req && m_gnt;
        w = exp_win;
        if (m_rv && q.size() > 0) dummy = q.pop_front();
        if (granted) q.push_back(w);
        if (!mlocked) begin
            if (granted) begin
                mrr = (w + 1) % N;
                if (!wen[w] && add[w*AW +: 8] == CMD_OFF && CMDW > 1) begin
                    mlocked = 1; mowner = w; mwords = CMDW - 1; midle = 0;
                end
            end
        end else if (granted) begin
            midle = 0;
            if (!wen[w]) begin
                mwords--;
                if (mwords == 0) begin mlocked = 0; mrr = (mowner + 1) % N; end
            end
        end else if (!req[mowner]) begin
            midle++;
            if (midle >= TO) begin mlocked = 0; mrr = (mowner + 1) % N; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req = '0; m_gnt = 0;
        while ((q.size() > 0 || mlocked) && n < 40) begin
            m_rv = (q.size() > 0);
            @(negedge clk); predict(); advance();
            n++;
        end
        m_rv = 0;
        checks++;
        if (q.size() != 0 || mlocked) begin
            errors++;
            $display("FAIL drain_bound: outstanding %0d locked %0d, required 0 0", q.size(), mlocked);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; req = '0; wen = '0; add = '0; wdata = '0; be = '0;
        m_gnt = 0; m_rv = 0; m_rdata = '0; m_ropc = 0;
        q.delete(); mrr = 0; mlocked = 0; midle = 0; mwords = 0; mowner = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_req, gnt, rv, lock_err, busy, m_wen} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got %0h required 0", {m_req, gnt, rv, lock_err, busy, m_wen});
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({m_req, gnt, rv, lock_err, busy} !== '0) begin
            errors++; $display("FAIL post_reset_ctrl: got %0h required 0", {m_req, gnt, rv, lock_err, busy});
        end
        checks++;
        if (m_add !== '0 || m_id !== '0 || m_wdata !== '0 || m_be !== '0 || rdata !== '0) begin
            errors++; $display("FAIL post_reset_data: got add %0h id %0h required 0", m_add, m_id);
        end
        predict(); advance();
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 9; c++) begin
            for (int p = 0; p < N; p++) set_port(p, 1, 0, naddr(p));
            m_gnt = 1; m_rv = (q.size() > 0); m_rdata = $urandom;
            @(negedge clk); predict();
            checks++;
            if (gnt !== (N'(1) << (c % N))) begin
                errors++; $display("FAIL rr_gnt[%0d]: got %b required %b", c, gnt, N'(1) << (c % N));
            end
            checks++;
            if (rv !== ((c == 0) ? N'(0) : (N'(1) << ((c - 1) % N)))) begin
                errors++; $display("FAIL rr_rvalid[%0d]: got %b", c, rv);
            end
            checks++;
            if (rdata !== m_rdata) begin
                errors++; $display("FAIL rr_rdata[%0d]: got %h required %h", c, rdata, m_rdata);
            end
            advance();
        end
        drain();
    endtask

    task automatic test_fifo_full();
        int ngr;
        ngr = 0;
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < N; p++) set_port(p, 1, 1, naddr(p));
            m_gnt = 1; m_rv = 0;
            @(negedge clk); predict();
            if (gnt != '0) ngr++;
            checks++;
            if (m_req !== (c < MAXO)) begin
                errors++; $display("FAIL full_req[%0d]: got %b required %b", c, m_req, (c < MAXO));
            end
            advance();
        end
        checks++;
        if (ngr != MAXO) begin
            errors++; $display("FAIL full_grants: got %0d required %0d", ngr, MAXO);
        end
        m_rv = 1;
        @(negedge clk); predict();
        checks++;
        if (m_req !== 1'b1 || gnt === '0) begin
            errors++; $display("FAIL full_pop_grant: got req %b gnt %b required req 1 with grant", m_req, gnt);
        end
        checks++;
        if (rv !== exp_rv || exp_rv === '0) begin
            errors++; $display("FAIL full_pop_rvalid: got %b required %b", rv, exp_rv);
        end
        advance();
        drain();
    endtask

    task automatic test_lock_sequence();
        logic [N-1:0] seq [5];
        seq = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
        for (int c = 0; c < 5; c++) begin
            m_gnt = 1; m_rv = (q.size() > 0);
            if (c == 0) begin
                set_port(0, 1, 1, naddr(0)); set_port(1, 0, 1, naddr(1)); set_port(2, 0, 1, naddr(2));
            end else begin
                set_port(0, 1, 0, naddr(0));
                set_port(1, 1, 0, (c == 1) ? cmdaddr() : naddr(1));
                set_port(2, 1, 0, naddr(2));
            end
            @(negedge clk); predict();
            checks++;
            if (gnt !== seq[c]) begin
                errors++; $display("FAIL lock_seq_gnt[%0d]: got %b required %b", c, gnt, seq[c]);
            end
            if (c > 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL lock_seq_busy[%0d]: got %b required 1", c, busy);
                end
            end
            advance();
        end
        drain();
    endtask

    task automatic test_lock_timeout();
        int nerr;
        nerr = 0;
        m_gnt = 1; m_rv = 0;
        set_port(0, 0, 1, naddr(0)); set_port(1, 0, 1, naddr(1)); set_port(2, 1, 1, naddr(2));
        @(negedge clk); predict();
        checks++;
        if (gnt !== 3'b100) begin errors++; $display("FAIL to_prime: got %b required 100", gnt); end
        advance();
        set_port(2, 0, 1, naddr(2)); set_port(0, 1, 0, cmdaddr()); m_rv = (q.size() > 0);
        @(negedge clk); predict();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL to_open: got %b required 001", gnt); end
        advance();
        for (int k = 0; k < TO; k++) begin
            set_port(0, 0, 0, naddr(0)); set_port(1, 1, 0, naddr(1)); set_port(2, 1, 0, naddr(2));
            m_rv = (q.size() > 0);
            @(negedge clk); predict();
            if (lock_err === 1'b1) nerr++;
            checks++;
            if (gnt !== '0 || lock_err !== (k == TO - 1)) begin
                errors++; $display("FAIL to_idle[%0d]: got gnt %b err %b required 0 %b", k, gnt, lock_err, (k == TO - 1));
            end
            advance();
        end
        m_rv = (q.size() > 0);
        @(negedge clk); predict();
        if (lock_err === 1'b1) nerr++;
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL to_after: got %b required 010", gnt); end
        checks++;
        if (nerr != 1) begin errors++; $display("FAIL to_pulses: got %0d required 1", nerr); end
        advance();
        drain();
    endtask

    task automatic test_lock_read();
        logic [N-1:0] seq [6];
        bit           p1w [6];
        seq = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        p1w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            m_gnt = 1; m_rv = (q.size() > 0);
            set_port(0, 1, 0, naddr(0));
            set_port(1, c != 0, p1w[c], (c == 1) ? cmdaddr() : naddr(1));
            set_port(2, c != 0, 0, naddr(2));
            @(negedge clk); predict();
            checks++;
            if (gnt !== seq[c]) begin
                errors++; $display("FAIL lock_read_gnt[%0d]: got %b required %b", c, gnt, seq[c]);
            end
            advance();
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 3) == 0) a[7:0] = CMD_OFF;
                set_port(p, 1'($urandom), 1'($urandom), a);
            end
            m_gnt   = ($urandom_range(0, 3) != 0);
            m_rv    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_rdata = $urandom;
            m_ropc  = 1'($urandom);
            @(negedge clk); predict();
            checks++;
            if (m_req !== exp_req || gnt !== exp_gnt) begin
                errors++; $display("FAIL rnd_arb[%0d]: got req %b gnt %b required %b %b", c, m_req, gnt, exp_req, exp_gnt);
            end
            checks++;
            if (rv !== exp_rv || rdata !== m_rdata || ropc !== m_ropc) begin
                errors++; $display("FAIL rnd_resp[%0d]: got rv %b required %b", c, rv, exp_rv);
            end
            checks++;
            if (lock_err !== exp_err || busy !== exp_busy) begin
                errors++; $display("FAIL rnd_lock[%0d]: got err %b busy %b required %b %b", c, lock_err, busy, exp_err, exp_busy);
            end
            if (exp_req) begin
                checks++;
                if (m_add !== add[exp_win*AW +: AW] || m_wen !== wen[exp_win] ||
                    m_wdata !== wdata[exp_win*DW +: DW] || m_be !== be[exp_win*BW +: BW] ||
                    m_id !== IDW'(exp_win)) begin
                    errors++; $display("FAIL rnd_mux[%0d]: got id %0d add %h required id %0d", c, m_id, m_add, exp_win);
                end
            end
            advance();
        end
        m_ropc = 0;
        drain();
    endtask

    task automatic test_reset_midop();
        m_gnt = 1; m_rv = 0;
        set_port(0, 0, 1, naddr(0)); set_port(1, 0, 1, naddr(1)); set_port(2, 1, 1, naddr(2));
        @(negedge clk); predict(); advance();
        set_port(2, 0, 1, naddr(2)); set_port(0, 1, 0, cmdaddr());
        @(negedge clk); predict(); advance();
        set_port(0, 1, 0, naddr(0));
        @(negedge clk); predict();
        checks++;
        if (gnt !== 3'b001) begin errors++; $display("FAIL mid_setup_gnt: got %b required 001", gnt); end
        advance();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_setup_busy: got %b required 1", busy); end
        for (int p = 0; p < N; p++) set_port(p, 1, 0, naddr(p));
        m_rdata = 32'hDEAD_BEEF; m_ropc = 1;
        rst_n = 0;
        #1;
        checks++;
        if ({m_req, gnt, rv, lock_err, busy, m_wen, ropc} !== '0) begin
            errors++; $display("FAIL mid_rst_ctrl: got %0h required 0", {m_req, gnt, rv, lock_err, busy, m_wen, ropc});
        end
        checks++;
        if (m_add !== '0 || m_id !== '0 || m_wdata !== '0 || m_be !== '0 || rdata !== '0) begin
            errors++; $display("FAIL mid_rst_data: got add %h rdata %h required 0", m_add, rdata);
        end
        q.delete(); mlocked = 0; mrr = 0; midle = 0; mwords = 0;
        m_rdata = '0; m_ropc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk); predict();
        checks++;
        if (gnt !== 3'b001 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_after_rst: got gnt %b busy %b required 001 0", gnt, busy);
        end
        advance();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_fifo_full();
        test_lock_sequence();
        test_lock_timeout();
        test_lock_read();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
